// File: rtl/usr_pkg.sv
// ============================================================================
// usr_pkg : control encoding and sequencer state type shared by the USR and
//           its command sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

package usr_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/usr_cmd_sequencer.sv
// ============================================================================
// usr_cmd_sequencer : turns load / shift-by-N / hold commands into per-cycle
//                     universal shift register controls.  Rev 1.0
// ============================================================================
`default_nettype none

module usr_cmd_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       control,
  output logic [WIDTH-1:0] p_in,
  output logic             r_shift,
  output logic             l_shift,
  output logic             busy,
  output logic             done
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [1:0]       op;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (state == ST_IDLE) && cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op    <= CTRL_HOLD;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op  <= cmd_op;
        sh  <= cmd_data;
        cnt <= cmd_count;
      end else if (state == ST_SHIFT) begin
        // Rotating keeps data bits available when count exceeds WIDTH.
        sh  <= {sh[0], sh[WIDTH-1:1]};
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == CTRL_LOAD)
            state_nxt = ST_LOAD;
          else if ((cmd_op != CTRL_HOLD) && (cmd_count != '0))
            state_nxt = ST_SHIFT;
          else
            state_nxt = ST_DONE;
        end
      end
      ST_LOAD:  state_nxt = ST_DONE;
      ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode only from registered state so no input reaches an output.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    control   = CTRL_HOLD;
    p_in      = '0;
    r_shift   = 1'b0;
    l_shift   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD: begin
        control = CTRL_LOAD;
        p_in    = sh;
      end
      ST_SHIFT: begin
        control = op;
        r_shift = (op == CTRL_SHR) && sh[0];
        l_shift = (op == CTRL_SHL) && sh[0];
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_usr_cmd_sequencer.sv
// Scoreboard bench: sequencer driving a behavioural 4-bit USR, checked against
// a command-level reference model.
`default_nettype none

module tb_usr_cmd_sequencer;
  import usr_pkg::*;

  localparam int W = 4;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [C-1:0] cmd_count = '0;
  logic [1:0]   control;
  logic [W-1:0] p_in;
  logic         r_shift, l_shift, busy, done;
  logic [W-1:0] p_out;

  usr_cmd_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .control(control), .p_in(p_in), .r_shift(r_shift), .l_shift(l_shift),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register downstream of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) p_out <= '0;
    else case (control)
      CTRL_SHR:  p_out <= {r_shift, p_out[W-1:1]};
      CTRL_SHL:  p_out <= {p_out[W-2:0], l_shift};
      CTRL_LOAD: p_out <= p_in;
      default:   p_out <= p_out;
    endcase
  end

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] ctrl;
    logic [3:0] pin;
    logic       r;
    logic       l;
  } ctrl_ev_t;

  typedef struct {
    int         cyc;
    logic [3:0] pout;
  } done_ev_t;

  ctrl_ev_t   ctrl_q[$];
  done_ev_t   done_q[$];
  logic [3:0] ref_pout = '0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the expectations pushed by the driver.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (ctrl_q.size() != 0 && ctrl_q[0].cyc < cyc) begin
          chk("ctrl_missed", 32'(ctrl_q[0].cyc), 32'(cyc));
          void'(ctrl_q.pop_front());
        end
        while (done_q.size() != 0 && done_q[0].cyc < cyc) begin
          chk("done_missed", 32'(done_q[0].cyc), 32'(cyc));
          void'(done_q.pop_front());
        end
        chk("busy", 32'(busy), 32'(done_q.size() != 0));
        chk("cmd_ready", 32'(cmd_ready), 32'(done_q.size() == 0));
        if (ctrl_q.size() != 0 && ctrl_q[0].cyc == cyc) begin
          ctrl_ev_t e;
          e = ctrl_q.pop_front();
          chk("control", 32'(control), 32'(e.ctrl));
          chk("p_in", 32'(p_in), 32'(e.pin));
          chk("r_shift", 32'(r_shift), 32'(e.r));
          chk("l_shift", 32'(l_shift), 32'(e.l));
        end else begin
          chk("control_idle", 32'(control), 32'(CTRL_HOLD));
          chk("outs_idle", 32'({p_in, r_shift, l_shift}), 32'(0));
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("done_unexpected", 32'(done), 32'(0));
          end else begin
            done_ev_t d;
            d = done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(d.cyc));
            chk("p_out", 32'(p_out), 32'(d.pout));
          end
        end else if (done_q.size() != 0 && done_q[0].cyc == cyc) begin
          chk("done_absent", 32'(done), 32'(1));
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Presents one command, waits for the handshake, then records what the USR
  // must see in each following cycle and the register value at completion.
  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [2:0] count);
    int t;
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 40) begin
        chk("accept_timeout", 32'(n), 32'(0));
        finish_run();
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    t = cyc;
    if (op == CTRL_LOAD) begin
      ctrl_q.push_back('{t, CTRL_LOAD, data, 1'b0, 1'b0});
      ref_pout = data;
      done_q.push_back('{t + 1, data});
    end else if (op != CTRL_HOLD && count != 0) begin
      for (int i = 0; i < int'(count); i++) begin
        logic b;
        b = data[i % W];
        ctrl_q.push_back('{t + i, op, 4'b0000, (op == CTRL_SHR) ? b : 1'b0,
                           (op == CTRL_SHL) ? b : 1'b0});
        if (op == CTRL_SHR) ref_pout = {b, ref_pout[3:1]};
        else                ref_pout = {ref_pout[2:0], b};
      end
      done_q.push_back('{t + int'(count), ref_pout});
    end else begin
      done_q.push_back('{t, ref_pout});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (done_q.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 40) begin
        chk("drain_timeout", 32'(n), 32'(0));
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_p_out", 32'(p_out), 32'(0));

    issue(CTRL_LOAD, 4'b1010, 3'd0);
    issue(CTRL_SHR,  4'b0011, 3'd3);
    drain();
    chk("shr_result", 32'(p_out), 32'(4'b0111));
    issue(CTRL_LOAD, 4'b0000, 3'd0);
    issue(CTRL_SHL,  4'b0101, 3'd2);
    drain();
    chk("shl_result", 32'(p_out), 32'(4'b0010));
    issue(CTRL_SHR,  4'b1111, 3'd0);
    issue(CTRL_HOLD, 4'b1111, 3'd7);
    issue(CTRL_SHL,  4'b1001, 3'd5);
    issue(CTRL_SHR,  4'b0110, 3'd7);
    drain();

    // Reset during the second shift cycle must abandon the command silently.
    issue(CTRL_SHR, 4'b1011, 3'd5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ctrl_q.delete();
    done_q.delete();
    ref_pout = '0;
    repeat (8) @(posedge clk);
    #1;
    issue(CTRL_LOAD, 4'b0110, 3'd0);
    drain();
    chk("post_reset_load", 32'(p_out), 32'(4'b0110));

    for (int k = 0; k < 60; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
      issue(2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom));
    end
    drain();
    repeat (3) @(posedge clk);
    finish_run();
  end

  initial begin
    #200000;
    chk("global_timeout", 32'(1), 32'(0));
    finish_run();
  end

endmodule

`default_nettype wire
